// File: rtl/sd_upsize.sv
// Srdy/drdy width up-converter: packs `ratio` narrow beats into one wide word.
// Define SD_UPSIZE_LAST_EN to add c_last early close with p_mask/p_last outputs.
module sd_upsize #(
  parameter int unsigned in_width  = 8,
  parameter int unsigned ratio     = 4,
  parameter int unsigned out_width = in_width * ratio
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 c_srdy,
  output logic                 c_drdy,
  input  logic [in_width-1:0]  c_data,
`ifdef SD_UPSIZE_LAST_EN
  input  logic                 c_last,
`endif
  output logic                 p_srdy,
  input  logic                 p_drdy,
  output logic [out_width-1:0] p_data
`ifdef SD_UPSIZE_LAST_EN
  ,
  output logic [ratio-1:0]     p_mask,
  output logic                 p_last
`endif
);

  if (ratio < 2 || ratio > 16) begin : gen_bad_ratio
    $error("sd_upsize: ratio must be in 2..16");
  end
  if (out_width != in_width * ratio) begin : gen_bad_width
    $error("sd_upsize: out_width must equal in_width*ratio");
  end

  localparam int unsigned     CntW   = $clog2(ratio);
  localparam logic [CntW-1:0] CntMax = CntW'(ratio - 1);
  localparam logic [CntW-1:0] CntOne = CntW'(1);

  logic [CntW-1:0]      cnt_q, cnt_d;
  logic [out_width-1:0] acc_q, acc_d;
  logic [out_width-1:0] merged;
  logic                 p_srdy_q, p_srdy_d;
  logic [out_width-1:0] p_data_q, p_data_d;
  logic                 acc_done;
  logic                 last_beat;
  logic                 push;
  logic                 out_free;
  logic                 completing;

`ifdef SD_UPSIZE_LAST_EN
  logic             acc_done_q, acc_done_d;
  logic [ratio-1:0] p_mask_q, p_mask_d;
  logic             p_last_q, p_last_d;
  logic [ratio-1:0] lane_mask;

  assign last_beat = c_last;
  assign acc_done  = acc_done_q;
  assign p_mask    = p_mask_q;
  assign p_last    = p_last_q;

  // Lanes 0..cnt are valid; cnt is frozen while a closed word waits in acc.
  always_comb begin
    lane_mask = '0;
    for (int unsigned k = 0; k < ratio; k++) begin
      lane_mask[k] = (CntW'(k) <= cnt_q);
    end
  end
`else
  assign last_beat = 1'b0;
  assign acc_done  = 1'b0;
`endif

  // Registered state only, so p_drdy never reaches c_drdy combinationally.
  assign c_drdy     = ~acc_done & (~p_srdy_q | (cnt_q != CntMax));
  assign push       = c_srdy & c_drdy;
  assign out_free   = ~p_srdy_q | p_drdy;
  assign completing = push & ((cnt_q == CntMax) | last_beat);
  assign p_srdy     = p_srdy_q;
  assign p_data     = p_data_q;

  always_comb begin
    merged = acc_q;
    for (int unsigned k = 0; k < ratio; k++) begin
      if (cnt_q == CntW'(k)) merged[k*in_width +: in_width] = c_data;
    end
  end

  always_comb begin
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    p_srdy_d = p_srdy_q & ~p_drdy;
    p_data_d = p_data_q;
`ifdef SD_UPSIZE_LAST_EN
    acc_done_d = acc_done_q;
    p_mask_d   = p_mask_q;
    p_last_d   = p_last_q;
`endif
    if ((acc_done | completing) & out_free) begin
      // A parked word (acc_done) and a completing push are mutually exclusive.
      p_srdy_d = 1'b1;
      p_data_d = acc_done ? acc_q : merged;
      cnt_d    = '0;
      acc_d    = '0;
`ifdef SD_UPSIZE_LAST_EN
      acc_done_d = 1'b0;
      p_mask_d   = lane_mask;
      p_last_d   = acc_done_q | c_last;
`endif
`ifdef SD_UPSIZE_LAST_EN
    end else if (completing) begin
      acc_d      = merged;
      acc_done_d = 1'b1;
`endif
    end else if (push) begin
      acc_d = merged;
      cnt_d = cnt_q + CntOne;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q    <= '0;
      acc_q    <= '0;
      p_srdy_q <= 1'b0;
      p_data_q <= '0;
    end else begin
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      p_srdy_q <= p_srdy_d;
      p_data_q <= p_data_d;
    end
  end

`ifdef SD_UPSIZE_LAST_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      acc_done_q <= 1'b0;
      p_mask_q   <= '0;
      p_last_q   <= 1'b0;
    end else begin
      acc_done_q <= acc_done_d;
      p_mask_q   <= p_mask_d;
      p_last_q   <= p_last_d;
    end
  end
`endif

endmodule

// File: tb/tb_sd_upsize.sv
// Bench for sd_upsize (ratio 4, 8-bit beats): directed scenarios plus a random
// srdy/drdy run scored against a queue of accepted beats.
module tb_sd_upsize;

  localparam int unsigned Ratio    = 4;
  localparam int unsigned NumBeats = 10000;
  localparam int          MaxCyc   = 60000;

  logic        clk     = 1'b0;
  logic        reset_n = 1'b0;
  logic        c_srdy  = 1'b0;
  logic        c_drdy;
  logic [7:0]  c_data  = '0;
  logic        p_srdy;
  logic        p_drdy  = 1'b0;
  logic [31:0] p_data;
`ifdef SD_UPSIZE_LAST_EN
  logic        c_last  = 1'b0;
  logic [3:0]  p_mask;
  logic        p_last;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sd_upsize #(
    .in_width (8),
    .ratio    (Ratio)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .c_srdy  (c_srdy),
    .c_drdy  (c_drdy),
    .c_data  (c_data),
`ifdef SD_UPSIZE_LAST_EN
    .c_last  (c_last),
    .p_mask  (p_mask),
    .p_last  (p_last),
`endif
    .p_srdy  (p_srdy),
    .p_drdy  (p_drdy),
    .p_data  (p_data)
  );

  // Inputs change and outputs are sampled on the falling edge only.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    c_srdy  = 1'b0;
    p_drdy  = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (p_srdy !== 1'b0) begin errors++; $display("FAIL rst_p_srdy got %b want 0", p_srdy); end
    checks++; if (c_drdy !== 1'b1) begin errors++; $display("FAIL rst_c_drdy got %b want 1", c_drdy); end
    checks++; if (p_data !== 32'h0) begin errors++; $display("FAIL rst_p_data got %h want 0", p_data); end
    reset_n = 1'b1;
    tick();
    checks++; if (p_srdy !== 1'b0) begin errors++; $display("FAIL idle_p_srdy got %b want 0", p_srdy); end
    checks++; if (c_drdy !== 1'b1) begin errors++; $display("FAIL idle_c_drdy got %b want 1", c_drdy); end
    checks++; if (p_data !== 32'h0) begin errors++; $display("FAIL idle_p_data got %h want 0", p_data); end
  endtask

  task automatic test_reset_mid_word();
    p_drdy = 1'b1;
    c_srdy = 1'b1;
    c_data = 8'h11; tick();
    c_data = 8'h22; tick();
    c_srdy  = 1'b0;
    reset_n = 1'b0;
    #1;
    checks++; if (p_srdy !== 1'b0) begin errors++; $display("FAIL midrst_p_srdy got %b want 0", p_srdy); end
    checks++; if (c_drdy !== 1'b1) begin errors++; $display("FAIL midrst_c_drdy got %b want 1", c_drdy); end
    @(negedge clk);
    reset_n = 1'b1;
    tick();
    for (int i = 0; i < 4; i++) begin
      c_srdy = 1'b1;
      c_data = 8'(8'h31 + i);
      tick();
    end
    c_srdy = 1'b0;
    checks++; if (p_srdy !== 1'b1) begin errors++; $display("FAIL midrst_word_srdy got %b want 1", p_srdy); end
    checks++; if (p_data !== 32'h34333231) begin errors++; $display("FAIL midrst_word got %h want 34333231", p_data); end
    tick();
    checks++; if (p_srdy !== 1'b0) begin errors++; $display("FAIL midrst_pop got %b want 0", p_srdy); end
  endtask

  task automatic test_streaming();
    logic [7:0] beats [8];
    beats = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
    p_drdy = 1'b1;
    for (int i = 0; i < 8; i++) begin
      c_srdy = 1'b1;
      c_data = beats[i];
      checks++; if (c_drdy !== 1'b1) begin errors++; $display("FAIL stream_c_drdy beat %0d got %b want 1", i, c_drdy); end
      tick();
      if (i == 3) begin
        checks++; if (p_srdy !== 1'b1 || p_data !== 32'h44332211) begin
          errors++; $display("FAIL stream_word0 got srdy=%b %h want 1 44332211", p_srdy, p_data);
        end
      end else if (i == 7) begin
        checks++; if (p_srdy !== 1'b1 || p_data !== 32'h88776655) begin
          errors++; $display("FAIL stream_word1 got srdy=%b %h want 1 88776655", p_srdy, p_data);
        end
      end else begin
        checks++; if (p_srdy !== 1'b0) begin errors++; $display("FAIL stream_gap beat %0d got %b want 0", i, p_srdy); end
      end
    end
    c_srdy = 1'b0;
    tick();
    checks++; if (p_srdy !== 1'b0) begin errors++; $display("FAIL stream_drain got %b want 0", p_srdy); end
  endtask

  task automatic test_backpressure();
    logic [7:0] tail [3];
    tail = '{8'hAA, 8'hBB, 8'hCC};
    p_drdy = 1'b0;
    for (int i = 0; i < 4; i++) begin
      c_srdy = 1'b1;
      c_data = 8'(i + 1);
      tick();
    end
    checks++; if (p_srdy !== 1'b1 || p_data !== 32'h04030201) begin
      errors++; $display("FAIL bp_held got srdy=%b %h want 1 04030201", p_srdy, p_data);
    end
    for (int i = 0; i < 3; i++) begin
      c_data = tail[i];
      checks++; if (c_drdy !== 1'b1) begin errors++; $display("FAIL bp_accept lane %0d got %b want 1", i, c_drdy); end
      tick();
    end
    c_data = 8'hDD;
    for (int i = 0; i < 3; i++) begin
      checks++; if (c_drdy !== 1'b0) begin errors++; $display("FAIL bp_stall cyc %0d got %b want 0", i, c_drdy); end
      checks++; if (p_srdy !== 1'b1 || p_data !== 32'h04030201) begin
        errors++; $display("FAIL bp_stable cyc %0d got srdy=%b %h want 1 04030201", i, p_srdy, p_data);
      end
      tick();
    end
    p_drdy = 1'b1;
    tick();
    checks++; if (p_srdy !== 1'b0) begin errors++; $display("FAIL bp_pop got %b want 0", p_srdy); end
    checks++; if (c_drdy !== 1'b1) begin errors++; $display("FAIL bp_resume got %b want 1", c_drdy); end
    tick();
    checks++; if (p_srdy !== 1'b1 || p_data !== 32'hDDCCBBAA) begin
      errors++; $display("FAIL bp_word got srdy=%b %h want 1 ddccbbaa", p_srdy, p_data);
    end
    c_srdy = 1'b0;
    tick();
    checks++; if (p_srdy !== 1'b0) begin errors++; $display("FAIL bp_drain got %b want 0", p_srdy); end
  endtask

`ifdef SD_UPSIZE_LAST_EN
  task automatic test_early_close();
    p_drdy = 1'b1;
    c_srdy = 1'b1;
    c_data = 8'hA1; c_last = 1'b0; tick();
    c_data = 8'hA2; c_last = 1'b1; tick();
    c_srdy = 1'b0;
    c_last = 1'b0;
    checks++; if (p_srdy !== 1'b1 || p_data !== 32'h0000A2A1) begin
      errors++; $display("FAIL early_word got srdy=%b %h want 1 0000a2a1", p_srdy, p_data);
    end
    checks++; if (p_mask !== 4'b0011) begin errors++; $display("FAIL early_mask got %b want 0011", p_mask); end
    checks++; if (p_last !== 1'b1) begin errors++; $display("FAIL early_last got %b want 1", p_last); end
    for (int i = 0; i < 4; i++) begin
      c_srdy = 1'b1;
      c_data = 8'(8'hC0 + i);
      tick();
    end
    c_srdy = 1'b0;
    checks++; if (p_data !== 32'hC3C2C1C0 || p_mask !== 4'b1111 || p_last !== 1'b0) begin
      errors++; $display("FAIL early_next got %h m=%b l=%b want c3c2c1c0 1111 0", p_data, p_mask, p_last);
    end
    tick();
  endtask

  task automatic test_last_blocked();
    p_drdy = 1'b0;
    for (int i = 0; i < 4; i++) begin
      c_srdy = 1'b1;
      c_data = 8'(8'h51 + i);
      tick();
    end
    c_data = 8'hB1; tick();
    c_data = 8'hB2; c_last = 1'b1;
    checks++; if (c_drdy !== 1'b1) begin errors++; $display("FAIL blk_accept got %b want 1", c_drdy); end
    tick();
    c_srdy = 1'b0;
    c_last = 1'b0;
    checks++; if (c_drdy !== 1'b0) begin errors++; $display("FAIL blk_stall got %b want 0", c_drdy); end
    checks++; if (p_data !== 32'h54535251) begin errors++; $display("FAIL blk_held got %h want 54535251", p_data); end
    p_drdy = 1'b1;
    tick();
    checks++; if (p_srdy !== 1'b1 || p_data !== 32'h0000B2B1) begin
      errors++; $display("FAIL blk_xfer got srdy=%b %h want 1 0000b2b1", p_srdy, p_data);
    end
    checks++; if (p_mask !== 4'b0011 || p_last !== 1'b1) begin
      errors++; $display("FAIL blk_meta got m=%b l=%b want 0011 1", p_mask, p_last);
    end
    checks++; if (c_drdy !== 1'b1) begin errors++; $display("FAIL blk_resume got %b want 1", c_drdy); end
    tick();
    checks++; if (p_srdy !== 1'b0) begin errors++; $display("FAIL blk_drain got %b want 0", p_srdy); end
  endtask
`endif

  task automatic test_random();
    logic [7:0]  in_q [$];
    int          accepted = 0;
    int          popped = 0;
    int          cyc = 0;
    logic        prev_hold = 1'b0;
    logic [31:0] prev_data = '0;
    logic        exp_srdy;
    logic        exp_drdy;
    logic [31:0] exp_word;
    reset_n = 1'b0;
    c_srdy  = 1'b0;
    p_drdy  = 1'b0;
    tick();
    reset_n = 1'b1;
    tick();
    while ((accepted < NumBeats || popped < NumBeats / Ratio) && cyc < MaxCyc) begin
      // A word exists once Ratio beats are in; it leaves the cycle it is popped.
      exp_srdy = ((accepted / Ratio) > popped);
      exp_drdy = !(exp_srdy && (accepted % Ratio) == Ratio - 1);
      checks++; if (p_srdy !== exp_srdy) begin
        errors++; $display("FAIL rnd_p_srdy cyc %0d got %b want %b", cyc, p_srdy, exp_srdy);
      end
      checks++; if (c_drdy !== exp_drdy) begin
        errors++; $display("FAIL rnd_c_drdy cyc %0d got %b want %b", cyc, c_drdy, exp_drdy);
      end
      if (prev_hold) begin
        checks++; if (p_data !== prev_data) begin
          errors++; $display("FAIL rnd_stable cyc %0d got %h want %h", cyc, p_data, prev_data);
        end
      end
      c_srdy = (accepted < NumBeats) && ($urandom_range(99) < 30);
      c_data = 8'($urandom);
      p_drdy = ($urandom_range(99) < 70);
      if (c_srdy && c_drdy) begin
        in_q.push_back(c_data);
        accepted++;
      end
      if (p_srdy && p_drdy) begin
        exp_word = '0;
        if (in_q.size() < Ratio) begin
          checks++; errors++;
          $display("FAIL rnd_dup cyc %0d got word %h with %0d beats queued want >=4", cyc, p_data, in_q.size());
        end else begin
          for (int k = 0; k < Ratio; k++) exp_word[k*8 +: 8] = in_q.pop_front();
          checks++; if (p_data !== exp_word) begin
            errors++; $display("FAIL rnd_word %0d got %h want %h", popped, p_data, exp_word);
          end
        end
        popped++;
      end
      prev_hold = p_srdy && !p_drdy;
      prev_data = p_data;
      cyc++;
      tick();
    end
    c_srdy = 1'b0;
    p_drdy = 1'b0;
    checks++; if (cyc >= MaxCyc) begin
      errors++; $display("FAIL rnd_timeout got %0d words want %0d", popped, NumBeats / Ratio);
    end
    checks++; if (in_q.size() != 0) begin
      errors++; $display("FAIL rnd_leftover got %0d beats want 0", in_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_reset_mid_word();
    test_streaming();
    test_backpressure();
`ifdef SD_UPSIZE_LAST_EN
    test_early_close();
    test_last_blocked();
`endif
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sd_upsize.md
Name: sd_upsize

Overview:
- Srdy/drdy width up-converter (gearbox).
- Collects `ratio` consecutive narrow beats into one wide word.
- Sits directly upstream of the closure stage (sd_iofull) on wide datapaths and feeds it.
- All output-side and c_drdy control comes from flops; there is no combinational path from p_drdy to c_drdy.

Parameters:
- in_width, 8, width of each consumer-side beat.
- ratio, 4, beats per output word; legal range 2..16.
- out_width, in_width*ratio, derived width of p_data; never overridden.

Ports:
- clk  input  1  clock; all flops on posedge.
- reset_n  input  1  reset, asynchronous, active-low.
- c_srdy  input  1  upstream beat valid.
- c_drdy  output  1  stage accepts a beat this cycle.
- c_data  input  in_width  upstream beat.
- c_last  input  1  final beat of a packet; closes the word early (SD_UPSIZE_LAST_EN only).
- p_srdy  output  1  wide word valid.
- p_drdy  input  1  downstream accepts the word.
- p_data  output  out_width  assembled word; lane k = p_data[k*in_width +: in_width].
- p_mask  output  ratio  lane-valid bits (SD_UPSIZE_LAST_EN only).
- p_last  output  1  word closed by c_last (SD_UPSIZE_LAST_EN only).

Behaviour:
- Reset (async assert, sync release): cnt=0, acc=0, acc_done=0, p_srdy=0, p_data=0, p_mask=0, p_last=0. c_drdy therefore reads 1.
- A reset mid-word discards the partial accumulator and any held output word.
- Handshake definitions:
  - push = c_srdy & c_drdy.
  - pop = p_srdy & p_drdy.
  - Once p_srdy is asserted, p_data, p_mask and p_last are held stable until pop.
- Accumulator:
  - On push, c_data is written into lane cnt of acc.
  - Lane 0 is the first beat, placed at the LSBs.
  - cnt increments modulo ratio.
- Word completion:
  - A push is completing when cnt==ratio-1, or when c_last=1 (if enabled).
- out_free = !p_srdy | p_drdy.
- Completing push with out_free=1:
  - Next cycle: p_srdy=1.
  - p_data = acc with the new lane merged in; unfilled lanes are zero.
  - p_mask = lanes 0..cnt set.
  - p_last = c_last.
  - Then cnt=0 and acc=0.
  - Latency is 1 cycle from the completing beat to p_srdy.
- Completing push with out_free=0:
  - Only reachable via c_last.
  - acc_done=1; the word stays in acc.
  - cnt is frozen.
- While acc_done=1, acc transfers to the output on the first cycle with out_free=1. After the transfer, acc_done=0, cnt=0 and acc=0.
- c_drdy = !acc_done & (!p_srdy | cnt!=ratio-1). It is built from registered state only.
- Pop without a new completion clears p_srdy next cycle.
- Pop in the same cycle as a completion reloads the output back-to-back, with no bubble.
- Throughput: with p_drdy held at 1, one beat is accepted every cycle and one word is produced every ratio cycles.
- Stall and boundary cases:
  - Output full and cnt==ratio-1: c_drdy=0 until pop.
  - Output full and cnt<ratio-1: non-last beats are still accepted.
- Width rules:
  - cnt is $clog2(ratio) bits.
  - ratio outside 2..16 is an elaboration error.

Optional Feature:
- Macro: SD_UPSIZE_LAST_EN.
- Defined:
  - The c_last, p_mask and p_last ports exist.
  - Early packet close and partial words behave as described above.
- Undefined:
  - Those ports are absent.
  - Words complete only at cnt==ratio-1.
  - acc_done logic is removed (constant 0).
  - Every output word is full.

Test Plan:
- Reset/idle: hold reset_n=0, then release. Require p_srdy=0, c_drdy=1, p_data=0. Assert reset_n=0 mid-word after 2 beats → next word starts at lane 0.
- Streaming: ratio=4, beats 0x11,0x22,0x33,0x44,0x55..0x88, p_drdy=1 → p_data=0x44332211 on the cycle after beat 4, then 0x88776655 exactly 4 cycles later; c_drdy never drops.
- Backpressure: p_drdy=0 with one word held, push 3 more beats → c_drdy=0 at cnt=3. p_data stays stable. Raise p_drdy → 4th beat accepted, next word 0xDDCCBBAA delivered intact.
- Early close (LAST_EN): beats 0xA1,0xA2 with c_last on the 2nd → p_data=0x0000A2A1, p_mask=4'b0011, p_last=1.
- Last with output blocked (LAST_EN): output held, c_last on lane 1 → c_drdy=0 (acc_done). The pop transfers the word the same cycle, and c_drdy returns to 1 the next cycle.
- Random srdy/drdy (30%/70%), 10k beats → scoreboard: no loss, no duplication, lane order preserved; p_data stable while p_srdy=1 and p_drdy=0.
